// File: rtl/calc_key_sequencer_if.sv
// Keypad / calculator handshake bundle around the key sequencer.
// slave = sequencer side, master = keypad decoder plus calculator side.
interface calc_key_sequencer_if;
   logic       key_valid;
   logic [7:0] key_code;
   logic       calc_done;
   logic [7:0] calc_result;
   logic [7:0] operand1;
   logic [7:0] operand2;
   logic [7:0] operator;
   logic       start_calc;
   logic [7:0] disp_value;
   logic       busy;
   logic       err;

   modport slave (
      input  key_valid, key_code, calc_done, calc_result,
      output operand1, operand2, operator, start_calc, disp_value, busy, err
   );

   modport master (
      output key_valid, key_code, calc_done, calc_result,
      input  operand1, operand2, operator, start_calc, disp_value, busy, err
   );
endinterface

// File: rtl/calc_key_sequencer.sv
// Turns ASCII keypad strobes into operand/operator requests for the 8-bit
// calculator, waits for its completion pulse and holds the result for display.
//
// state  | meaning
// S_A    | entering operand1
// S_OP   | operator chosen, waiting for first digit of operand2
// S_B    | entering operand2
// S_CALC | start_calc pulse cycle
// S_WAIT | waiting for calc_done, timeout down-counter running
// S_RES  | result latched in operand1 and displayed
module calc_key_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   calc_key_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_OP   = 3'd1,
      S_B    = 3'd2,
      S_CALC = 3'd3,
      S_WAIT = 3'd4,
      S_RES  = 3'd5
   } state_t;

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

   state_t        state_q;
   logic [7:0]    op1_q;
   logic [7:0]    op2_q;
   logic [7:0]    opr_q;
   logic          start_q;
   logic          err_q;
   logic [TW-1:0] tmr_q;

   logic       is_digit;
   logic       is_oper;
   logic       is_eq;
   logic       is_clr;
   logic [3:0] digit_val;
   logic [8:0] acc1;
   logic [8:0] acc2;

   // Result bit 8 flags saturation; 255*10+9 still fits in 12 bits.
   function automatic logic [8:0] accumulate(input logic [7:0] old, input logic [3:0] d);
      logic [11:0] sum;
      sum = ({4'd0, old} * 12'd10) + {8'd0, d};
      if (sum > 12'd255) begin
         return {1'b1, 8'hFF};
      end
      return {1'b0, sum[7:0]};
   endfunction

   always_comb begin
      is_digit  = bus.key_valid && (bus.key_code >= 8'd48) && (bus.key_code <= 8'd57);
      is_oper   = bus.key_valid && ((bus.key_code == 8'd42) || (bus.key_code == 8'd43) ||
                                    (bus.key_code == 8'd45) || (bus.key_code == 8'd47));
      is_eq     = bus.key_valid && (bus.key_code == 8'd61);
      is_clr    = bus.key_valid && (bus.key_code == 8'd67);
      // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
      digit_val = bus.key_code[3:0];
      acc1      = accumulate(op1_q, digit_val);
      acc2      = accumulate(op2_q, digit_val);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_A;
         op1_q   <= 8'd0;
         op2_q   <= 8'd0;
         opr_q   <= 8'd0;
         start_q <= 1'b0;
         err_q   <= 1'b0;
         tmr_q   <= '0;
      end else begin
         start_q <= 1'b0;
         if (is_clr && (state_q != S_CALC) && (state_q != S_WAIT)) begin
            state_q <= S_A;
            op1_q   <= 8'd0;
            op2_q   <= 8'd0;
            opr_q   <= 8'd0;
            err_q   <= 1'b0;
         end else begin
            case (state_q)
               S_A: begin
                  if (is_digit) begin
                     op1_q <= acc1[7:0];
                     if (acc1[8]) err_q <= 1'b1;
                  end else if (is_oper) begin
                     opr_q   <= bus.key_code;
                     op2_q   <= 8'd0;
                     state_q <= S_OP;
                  end
               end
               S_OP: begin
                  if (is_digit) begin
                     op2_q   <= {4'd0, digit_val};
                     state_q <= S_B;
                  end else if (is_oper) begin
                     opr_q <= bus.key_code;
                  end
               end
               S_B: begin
                  if (is_digit) begin
                     op2_q <= acc2[7:0];
                     if (acc2[8]) err_q <= 1'b1;
                  end else if (is_eq) begin
                     start_q <= 1'b1;
                     state_q <= S_CALC;
                     if ((opr_q == 8'd47) && (op2_q == 8'd0)) err_q <= 1'b1;
                  end
               end
               S_CALC: begin
                  tmr_q   <= TMR_LOAD;
                  state_q <= S_WAIT;
               end
               S_WAIT: begin
                  // calc_done takes priority over a timeout on the same edge.
                  if (bus.calc_done) begin
                     op1_q   <= bus.calc_result;
                     state_q <= S_RES;
                  end else if (tmr_q == '0) begin
                     err_q   <= 1'b1;
                     op1_q   <= 8'd0;
                     op2_q   <= 8'd0;
                     state_q <= S_A;
                  end else begin
                     tmr_q <= tmr_q - 1'b1;
                  end
               end
               S_RES: begin
                  if (is_digit) begin
                     op1_q   <= {4'd0, digit_val};
                     op2_q   <= 8'd0;
                     state_q <= S_A;
                  end else if (is_oper) begin
                     opr_q   <= bus.key_code;
                     op2_q   <= 8'd0;
                     state_q <= S_OP;
                  end
               end
               default: state_q <= S_A;
            endcase
         end
      end
   end

   assign bus.operand1   = op1_q;
   assign bus.operand2   = op2_q;
   assign bus.operator   = opr_q;
   assign bus.start_calc = start_q;
   assign bus.err        = err_q;
   assign bus.busy       = (state_q == S_CALC) || (state_q == S_WAIT);
   assign bus.disp_value = ((state_q == S_B) || (state_q == S_CALC) || (state_q == S_WAIT))
                           ? op2_q : op1_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer: directed scenarios with literal expectations,
// then random key traffic, all checked every cycle against a behavioural model.
module tb_calc_key_sequencer;
   localparam int TO = 16;
   localparam int P_A = 0, P_OP = 1, P_B = 2, P_REQ = 3, P_WAIT = 4, P_RES = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   calc_key_sequencer_if bus ();
   calc_key_sequencer #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int total = 0;
   int bad   = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [2:0] ph;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op;
      logic       e;
      logic [7:0] w;
   } mst_t;

   mst_t m;

   function automatic mst_t step(mst_t s, logic kv, logic [7:0] kc, logic cd, logic [7:0] cr);
      mst_t n = s;
      int   v, ph;
      bit   dig, opk, eq, clr;
      ph  = int'(s.ph);
      dig = kv && (kc >= 8'd48) && (kc <= 8'd57);
      opk = kv && (kc == 8'd42 || kc == 8'd43 || kc == 8'd45 || kc == 8'd47);
      eq  = kv && (kc == 8'd61);
      clr = kv && (kc == 8'd67);
      v   = int'(kc) - 48;
      if (clr && ph != P_REQ && ph != P_WAIT) return '0;
      case (ph)
         P_A: if (dig) begin
            v = int'(s.a) * 10 + v;
            if (v > 255) begin v = 255; n.e = 1'b1; end
            n.a = v[7:0];
         end else if (opk) begin
            n.op = kc; n.b = 8'd0; n.ph = 3'(P_OP);
         end
         P_OP: if (dig) begin
            n.b = v[7:0]; n.ph = 3'(P_B);
         end else if (opk) n.op = kc;
         P_B: if (dig) begin
            v = int'(s.b) * 10 + v;
            if (v > 255) begin v = 255; n.e = 1'b1; end
            n.b = v[7:0];
         end else if (eq) begin
            n.ph = 3'(P_REQ);
            if (s.op == 8'd47 && s.b == 8'd0) n.e = 1'b1;
         end
         P_REQ: begin n.ph = 3'(P_WAIT); n.w = 8'd0; end
         P_WAIT: if (cd) begin
            n.a = cr; n.ph = 3'(P_RES);
         end else if (int'(s.w) + 1 == TO) begin
            n.e = 1'b1; n.a = 8'd0; n.b = 8'd0; n.ph = 3'(P_A);
         end else n.w = s.w + 8'd1;
         P_RES: if (dig) begin
            n.a = v[7:0]; n.b = 8'd0; n.ph = 3'(P_A);
         end else if (opk) begin
            n.op = kc; n.b = 8'd0; n.ph = 3'(P_OP);
         end
         default: n = '0;
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) m <= '0;
      else        m <= step(m, bus.key_valid, bus.key_code, bus.calc_done, bus.calc_result);

   bit chk_en = 0;
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         int ph;
         ph = int'(m.ph);
         check("operand1", 32'(bus.operand1), 32'(m.a));
         check("operand2", 32'(bus.operand2), 32'(m.b));
         check("operator", 32'(bus.operator), 32'(m.op));
         check("err", 32'(bus.err), 32'(m.e));
         check("start_calc", 32'(bus.start_calc), 32'(ph == P_REQ));
         check("busy", 32'(bus.busy), 32'(ph == P_REQ || ph == P_WAIT));
         check("disp_value", 32'(bus.disp_value),
               (ph == P_B || ph == P_REQ || ph == P_WAIT) ? 32'(m.b) : 32'(m.a));
      end
   end

   // ---------------- calculator responder ----------------
   bit         resp_en = 0;
   bit         rand_lat = 0;
   bit         spur_en = 0;
   int         fixed_lat = 1;
   int         lat_cnt = 0;
   logic [7:0] resp_val = 8'd0;
   bit         force_done = 0;
   logic [7:0] force_val = 8'd0;
   int         lat_tab[9] = '{1, 1, 1, 2, 3, 5, 16, 17, 20};

   function automatic logic [7:0] calc(logic [7:0] a, logic [7:0] b, logic [7:0] op);
      case (op)
         8'd43:   return a + b;
         8'd45:   return a - b;
         8'd42:   return 8'((int'(a) * int'(b)) % 256);
         8'd47:   return (b == 8'd0) ? 8'd0 : a / b;
         default: return 8'd0;
      endcase
   endfunction

   always @(negedge clk) begin
      bus.calc_done   = 1'b0;
      bus.calc_result = 8'($urandom);
      if (lat_cnt > 0) begin
         lat_cnt--;
         if (lat_cnt == 0) begin
            bus.calc_done   = 1'b1;
            bus.calc_result = resp_val;
         end
      end else if (spur_en && $urandom_range(0, 19) == 0) begin
         bus.calc_done = 1'b1;
      end
      if (force_done) begin
         bus.calc_done   = 1'b1;
         bus.calc_result = force_val;
         force_done      = 0;
      end
      if (resp_en && bus.start_calc === 1'b1) begin
         resp_val = calc(bus.operand1, bus.operand2, bus.operator);
         lat_cnt  = rand_lat ? lat_tab[$urandom_range(0, 8)] : fixed_lat;
      end
   end

   // ---------------- stimulus ----------------
   task automatic press(byte c);
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = c;
      @(negedge clk);
      bus.key_valid = 1'b0;
   endtask

   task automatic press_str(string s);
      for (int i = 0; i < s.len(); i++) press(s[i]);
   endtask

   function automatic logic [7:0] rand_key();
      int r;
      byte ops[4] = '{8'd42, 8'd43, 8'd45, 8'd47};
      r = $urandom_range(0, 99);
      if (r < 50) return 8'(48 + $urandom_range(0, 9));
      if (r < 70) return ops[$urandom_range(0, 3)];
      if (r < 82) return 8'd61;
      if (r < 87) return 8'd67;
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      bus.key_valid = 1'b0;
      bus.key_code  = 8'd0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_op1", 32'(bus.operand1), 0);
      check("rst_opr", 32'(bus.operator), 0);
      check("rst_start", 32'(bus.start_calc), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_err", 32'(bus.err), 0);
      check("rst_disp", 32'(bus.disp_value), 0);
      #1 rst_n = 1'b1;
      chk_en  = 1;
      resp_en = 1;

      // basic add
      press_str("12+34=");
      check("add_start", 32'(bus.start_calc), 1);
      check("add_op1", 32'(bus.operand1), 12);
      check("add_op2", 32'(bus.operand2), 34);
      check("add_opr", 32'(bus.operator), 43);
      check("add_busy", 32'(bus.busy), 1);
      repeat (2) @(negedge clk);
      check("add_disp", 32'(bus.disp_value), 46);
      check("add_err", 32'(bus.err), 0);
      check("add_busy_lo", 32'(bus.busy), 0);
      check("model_res_state", 32'(m.ph), P_RES);

      // saturation then clear
      press("C");
      press_str("999");
      check("sat_op1", 32'(bus.operand1), 255);
      check("sat_err", 32'(bus.err), 1);
      press("C");
      check("clr_op1", 32'(bus.operand1), 0);
      check("clr_err", 32'(bus.err), 0);

      // chaining
      press_str("5*6=");
      repeat (2) @(negedge clk);
      check("chain_first", 32'(bus.disp_value), 30);
      press_str("-10=");
      check("chain_op1", 32'(bus.operand1), 30);
      check("chain_op2", 32'(bus.operand2), 10);
      check("chain_opr", 32'(bus.operator), 45);
      check("chain_start", 32'(bus.start_calc), 1);
      repeat (2) @(negedge clk);
      check("chain_disp", 32'(bus.disp_value), 20);
      check("model_chain", 32'(m.a), 20);

      // divide by zero
      press("C");
      press_str("7/0=");
      check("div0_err", 32'(bus.err), 1);
      check("div0_start", 32'(bus.start_calc), 1);
      repeat (2) @(negedge clk);
      check("div0_disp", 32'(bus.disp_value), 0);

      // timeout
      press("C");
      resp_en = 0;
      press_str("1+2=");
      repeat (TO) @(negedge clk);
      check("to_last_wait_busy", 32'(bus.busy), 1);
      check("to_last_wait_err", 32'(bus.err), 0);
      @(negedge clk);
      check("to_err", 32'(bus.err), 1);
      check("to_busy", 32'(bus.busy), 0);
      check("to_op1", 32'(bus.operand1), 0);
      check("to_disp", 32'(bus.disp_value), 0);

      // calc_done on the timeout edge wins
      press("C");
      resp_en   = 1;
      fixed_lat = TO;
      press_str("2*3=");
      repeat (TO + 1) @(negedge clk);
      check("tie_disp", 32'(bus.disp_value), 6);
      check("tie_err", 32'(bus.err), 0);
      check("tie_busy", 32'(bus.busy), 0);
      fixed_lat = 1;

      // busy lockout, then reset mid-wait and a late calc_done
      press("C");
      resp_en = 0;
      press_str("3+4=");
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = 8'd56;
      @(negedge clk);
      bus.key_code  = 8'd67;
      @(negedge clk);
      bus.key_valid = 1'b0;
      check("lock_op1", 32'(bus.operand1), 3);
      check("lock_op2", 32'(bus.operand2), 4);
      check("lock_opr", 32'(bus.operator), 43);
      check("lock_busy", 32'(bus.busy), 1);
      check("lock_disp", 32'(bus.disp_value), 4);
      #2 rst_n = 1'b0;
      #1;
      check("amid_op1", 32'(bus.operand1), 0);
      check("amid_op2", 32'(bus.operand2), 0);
      check("amid_opr", 32'(bus.operator), 0);
      check("amid_busy", 32'(bus.busy), 0);
      check("amid_disp", 32'(bus.disp_value), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      force_val  = 8'd99;
      force_done = 1;
      repeat (3) @(negedge clk);
      check("late_disp", 32'(bus.disp_value), 0);
      check("late_busy", 32'(bus.busy), 0);
      check("late_op1", 32'(bus.operand1), 0);

      // random traffic
      resp_en  = 1;
      rand_lat = 1;
      spur_en  = 1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 9) < 4) begin
            bus.key_valid = 1'b1;
            bus.key_code  = rand_key();
         end else begin
            bus.key_valid = 1'b0;
         end
      end
      @(negedge clk);
      bus.key_valid = 1'b0;
      repeat (25) @(negedge clk);
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/calc_key_sequencer.md
# calc_key_sequencer

Controller that turns a stream of ASCII keypad codes into operations for the 8-bit calculator datapath. It accumulates two decimal operands and an operator, issues a single-cycle `start_calc`, waits for `calc_done`, and latches the result for display. It also supports chaining a result into the next operation. It sits between the keypad decoder (one-cycle `key_valid` pulses) and the calculator/display logic.

## Interface

- `TIMEOUT_CYC`, default 16: cycles to wait in S_WAIT for `calc_done` before flagging an error (≥2).
- `clk` in 1: system clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_valid` in 1: one-cycle strobe; `key_code` is valid in that cycle.
- `key_code` in 8: ASCII key. Accepted keys are '0'–'9' (48–57), '+' (43), '-' (45), '*' (42), '/' (47), '=' (61) and 'C' (67). All other codes are ignored.
- `calc_done` in 1: completion pulse from the calculator.
- `calc_result` in 8: calculator result, valid while `calc_done` = 1.
- `operand1` out 8: first operand to the calculator (registered).
- `operand2` out 8: second operand to the calculator (registered).
- `operator` out 8: ASCII operator to the calculator (registered).
- `start_calc` out 1: one-cycle request pulse (registered).
- `disp_value` out 8: number to display (combinational mux of registered values).
- `busy` out 1: 1 in S_CALC and S_WAIT.
- `err` out 1: sticky error flag.

## Operation

- **Reset values:** all registered outputs are 0 (`operator` = 8'd0), state = S_A.
- **Digit accumulate:** `new = old*10 + (key_code - 48)`, computed at ≥12 bits.
  - If the result exceeds 255, the operand saturates to 255 and `err` is set.
- **States and transitions** (a key is acted on only when `key_valid` = 1):
  - **S_A** (entering operand1):
    - digit → accumulate into `operand1`.
    - operator → `operator` = key, `operand2` = 0, go to S_OP.
    - '=' → ignored.
  - **S_OP** (operator chosen):
    - digit → `operand2` = digit, go to S_B.
    - operator → replaces `operator`.
    - '=' → ignored.
  - **S_B** (entering operand2):
    - digit → accumulate into `operand2`.
    - operator → ignored.
    - '=' → go to S_CALC. If `operator` = '/' and `operand2` = 0, also set `err`.
  - **S_CALC:** `start_calc` = 1 for exactly this cycle; clear the timeout counter; go to S_WAIT.
  - **S_WAIT:**
    - `calc_done` = 1 → `operand1` = `calc_result`, go to S_RES.
    - Otherwise increment the counter. When it reaches `TIMEOUT_CYC`: set `err`, `operand1` = 0, `operand2` = 0, go to S_A.
  - **S_RES** (result shown):
    - digit → `operand1` = digit, `operand2` = 0, go to S_A.
    - operator → chain: `operator` = key, `operand2` = 0, go to S_OP. `operand1` keeps the result.
    - '=' → ignored.
- **'C' key:** in S_A, S_OP, S_B and S_RES, clears operands, `operator` and `err`, and returns to S_A.
- **Busy states:** all keys, including 'C', are ignored in S_CALC and S_WAIT.
- **`disp_value`:**
  - `operand1` in S_A, S_OP and S_RES.
  - `operand2` in S_B, S_CALC and S_WAIT.
- **Operand stability:** `operand1`, `operand2` and `operator` do not change from entry to S_CALC until leaving S_WAIT.
- **`err`:** cleared only by 'C' or reset. It does not block operation.
- **Unexpected `calc_done`:** ignored when it arrives outside S_WAIT.

## Timing

- A key sampled at edge E0 updates registers and state visible after E0.
- For '=' sampled at E0:
  - `start_calc` is high in the cycle after E0.
  - The calculator registers its result at E1; `calc_done` is high after E1.
  - The controller latches the result at E2; `disp_value` shows it after E2.
  - `busy` is high for those two cycles.
- The timeout fires on the edge that would be the `TIMEOUT_CYC`-th consecutive S_WAIT cycle without `calc_done`.
- **Simultaneous events:** `calc_done` and timeout in the same cycle → `calc_done` wins.
- **Reset mid-operation:** asynchronous reset in any state forces reset values immediately, including mid-S_WAIT. A `calc_done` arriving after reset deasserts is ignored (state is S_A).

## Test plan

- **Basic add:** keys '1','2','+','3','4','=' → one `start_calc` pulse with `operand1`=12, `operand2`=34, `operator`=43. `calc_done` returns 46 → `disp_value`=46, state S_RES, `err`=0.
- **Saturation:** '9','9','9' → `operand1`=255, `err`=1. Then 'C' → `operand1`=0, `err`=0.
- **Chaining:** '5','*','6','=' (result 30), then '-','1','0','=' → second `start_calc` has `operand1`=30, `operand2`=10, `operator`=45. Display shows 20.
- **Divide by zero:** '7','/','0','=' → `err`=1, `start_calc` still pulses. Result 0 is displayed.
- **Timeout:** hold `calc_done`=0 after '=' → after 16 S_WAIT cycles `err`=1, state S_A, `operand1`=0, `busy`=0.
- **Busy lockout and reset:** keys '8' and 'C' pulsed during S_WAIT have no effect. Asserting `rst_n`=0 mid-S_WAIT clears all outputs immediately, and a late `calc_done` after release is ignored.
